// File: rtl/cell_vec_tester_if.sv
// Signal bundle between the vector tester and its environment (stimulus
// source plus the 3-input complex-gate cell under test). The expected truth
// table is carried as expect_tt because "expect" is a reserved word.
interface cell_vec_tester_if;
  logic       start;
  logic [7:0] expect_tt;
  logic [3:0] settle;
  logic       nq;
  logic       i0;
  logic       i1;
  logic       i2;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] errcnt;
  logic       fail_valid;
  logic [2:0] fail_vec;

  // Environment side: issues run requests and returns the cell output
  modport master (
    output start, expect_tt, settle, nq,
    input  i0, i1, i2, busy, done, pass, errcnt, fail_valid, fail_vec
  );

  // Tester side
  modport slave (
    input  start, expect_tt, settle, nq,
    output i0, i1, i2, busy, done, pass, errcnt, fail_valid, fail_vec
  );
endinterface

// File: rtl/cell_vec_tester.sv
// Exhaustive 3-input cell tester: walks vectors 0..7, drives them onto the
// cell, waits a programmable settle time, samples nq and compares it with the
// latched expected truth table. Reports mismatch count, first failing vector
// and an overall pass flag. nq is sampled directly as a synchronous input.
module cell_vec_tester (
  input  logic               ck,
  input  logic               rst,
  cell_vec_tester_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t     r_state;
  logic [7:0] r_expect;
  logic [3:0] r_settle;
  logic [3:0] r_cnt;
  logic [2:0] r_vec;
  logic [2:0] r_drive;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_errcnt;
  logic       r_fail_valid;
  logic [2:0] r_fail_vec;

  logic       w_mismatch;

  // Compare the cell output against the latched truth table entry for this vector
  assign w_mismatch = (bus.nq != r_expect[r_vec]);

  // Run sequencer: every output is registered here, reset forces an idle, all-zero state
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_expect     <= 8'd0;
      r_settle     <= 4'd0;
      r_cnt        <= 4'd0;
      r_vec        <= 3'd0;
      r_drive      <= 3'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_errcnt     <= 4'd0;
      r_fail_valid <= 1'b0;
      r_fail_vec   <= 3'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            // Freeze the run configuration so later input changes cannot disturb it
            r_expect     <= bus.expect_tt;
            r_settle     <= bus.settle;
            r_vec        <= 3'd0;
            r_errcnt     <= 4'd0;
            r_pass       <= 1'b0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= 3'd0;
            r_busy       <= 1'b1;
            r_state      <= APPLY;
          end
        end
        APPLY: begin
          r_drive <= r_vec;
          if (r_settle == 4'd0) begin
            r_state <= SAMPLE;
          end else begin
            r_cnt   <= r_settle;
            r_state <= SETTLE;
          end
        end
        SETTLE: begin
          // Leaving on a count of 1 gives exactly settle cycles in this state
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= SAMPLE;
          end
        end
        SAMPLE: begin
          // At most 8 mismatches per run, so the 4-bit count never wraps
          if (w_mismatch) begin
            r_errcnt <= r_errcnt + 4'd1;
            if (!r_fail_valid) begin
              r_fail_valid <= 1'b1;
              r_fail_vec   <= r_vec;
            end
          end
          if (r_vec == 3'd7) begin
            r_done  <= 1'b1;
            r_drive <= 3'd0;
            r_vec   <= 3'd0;
            r_pass  <= (r_errcnt == 4'd0) && !w_mismatch;
            r_state <= DONE;
          end else begin
            r_vec   <= r_vec + 3'd1;
            r_state <= APPLY;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.i0         = r_drive[0];
  assign bus.i1         = r_drive[1];
  assign bus.i2         = r_drive[2];
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.pass       = r_pass;
  assign bus.errcnt     = r_errcnt;
  assign bus.fail_valid = r_fail_valid;
  assign bus.fail_vec   = r_fail_vec;

endmodule

// File: tb/tb_cell_vec_tester.sv
// Scoreboard bench for cell_vec_tester: each run pushes the expected result
// computed from the cell truth table vs the expected table; a monitor pops and
// compares whenever done pulses.
module tb_cell_vec_tester;

  typedef struct {
    logic [3:0] errcnt;
    logic       fv;
    logic [2:0] fvec;
    logic       pass;
    int         lat;
  } exp_t;

  logic       ck;
  logic       rst;
  logic [7:0] cell_tt;
  int         cyc;
  int         start_edge;
  int         busy_run;
  int         checks;
  int         errors;
  exp_t       sb[$];

  cell_vec_tester_if bus ();

  cell_vec_tester dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  // Cell under test modelled as a truth table indexed by {i2,i1,i0}
  assign bus.nq = cell_tt[{bus.i2, bus.i1, bus.i0}];

  initial ck = 1'b0;
  always #5 ck = ~ck;

  always @(posedge ck) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: count table disagreements over all 8 vectors
  function automatic exp_t model(input logic [7:0] ctt, input logic [7:0] ex, input logic [3:0] s);
    exp_t e;
    e.errcnt = 4'd0;
    e.fv     = 1'b0;
    e.fvec   = 3'd0;
    for (int v = 0; v < 8; v++) begin
      if (ctt[v] != ex[v]) begin
        e.errcnt = e.errcnt + 4'd1;
        if (!e.fv) begin
          e.fv   = 1'b1;
          e.fvec = v[2:0];
        end
      end
    end
    e.pass = (e.errcnt == 4'd0);
    e.lat  = 8 * (int'(s) + 2);
    return e;
  endfunction

  // Monitor: compare DUT result against scoreboard head on each done pulse
  always @(negedge ck) begin
    if (rst) begin
      busy_run = 0;
    end else begin
      if (bus.busy) busy_run = busy_run + 1;
      else busy_run = 0;
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("run: errcnt=%0d fail_valid=%0d fail_vec=%0d pass=%0d latency=%0d (exp errcnt=%0d pass=%0d latency=%0d)",
                   bus.errcnt, bus.fail_valid, bus.fail_vec, bus.pass, cyc - start_edge,
                   e.errcnt, e.pass, e.lat);
          chk("errcnt", 32'(bus.errcnt), 32'(e.errcnt));
          chk("fail_valid", 32'(bus.fail_valid), 32'(e.fv));
          if (e.fv) chk("fail_vec", 32'(bus.fail_vec), 32'(e.fvec));
          chk("pass", 32'(bus.pass), 32'(e.pass));
          chk("drive_zero_at_done", 32'({bus.i2, bus.i1, bus.i0}), 32'd0);
          chk("done_latency", 32'(cyc - start_edge), 32'(e.lat));
          chk("busy_length", 32'(busy_run), 32'(e.lat + 1));
        end
      end
    end
  end

  task automatic run(input logic [7:0] ctt, input logic [7:0] ex, input logic [3:0] s, input bit disturb);
    exp_t e;
    bit   seen;
    cell_tt = ctt;
    e = model(ctt, ex, s);
    @(negedge ck);
    bus.expect_tt = ex;
    bus.settle    = s;
    bus.start     = 1'b1;
    sb.push_back(e);
    start_edge = cyc + 1;
    @(negedge ck);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < e.lat + 20; k++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (disturb) begin
        bus.start     = 1'($urandom_range(0, 1));
        bus.expect_tt = 8'($urandom);
        bus.settle    = 4'($urandom);
      end
      @(negedge ck);
    end
    bus.start = 1'b0;
    if (!seen) begin
      chk("done_timeout", 32'd0, 32'd1);
      sb.delete();
    end
    @(negedge ck);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("pass_held", 32'(bus.pass), 32'(e.pass));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_drive"}, 32'({bus.i2, bus.i1, bus.i0}), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_pass"}, 32'(bus.pass), 32'd0);
    chk({tag, "_errcnt"}, 32'(bus.errcnt), 32'd0);
    chk({tag, "_fail"}, 32'({bus.fail_valid, bus.fail_vec}), 32'd0);
  endtask

  initial begin
    cyc        = 0;
    checks     = 0;
    errors     = 0;
    busy_run   = 0;
    start_edge = 0;
    cell_tt    = 8'h00;
    rst        = 1'b1;
    bus.start     = 1'b0;
    bus.expect_tt = 8'h00;
    bus.settle    = 4'd0;
    repeat (3) @(negedge ck);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge ck);
    chk_all_zero("after_reset");

    // Correct cell nq = ~((i0&i1)|i2) has truth table 8'h07
    run(8'h07, 8'h07, 4'd0, 1'b0);
    run(8'h00, 8'h07, 4'd0, 1'b0);
    run(8'hFF, 8'h07, 4'd2, 1'b0);
    run(8'h07, 8'h07, 4'd15, 1'b0);
    run(8'h07, 8'h07, 4'd3, 1'b1);
    run(8'hA5, 8'h07, 4'd1, 1'b1);

    // Reset during vector 4 of a settle=1 run (vector 4 applied at start edge + 13)
    cell_tt = 8'h00;
    @(negedge ck);
    bus.expect_tt = 8'h07;
    bus.settle    = 4'd1;
    bus.start     = 1'b1;
    @(negedge ck);
    bus.start = 1'b0;
    repeat (13) @(posedge ck);
    #2;
    chk("pre_reset_errcnt", 32'(bus.errcnt), 32'd3);
    chk("pre_reset_drive", 32'({bus.i2, bus.i1, bus.i0}), 32'd4);
    rst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    @(negedge ck);
    rst = 1'b0;
    run(8'h00, 8'h07, 4'd1, 1'b0);

    // Randomized runs
    for (int r = 0; r < 12; r++) begin
      run(8'($urandom), 8'($urandom), 4'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge ck);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
